// File: rtl/rx_bit_sampler.sv
// UART receive oversampling front end: edge/bit counting, 3-sample majority vote per bit.
// Optional input synchroniser enabled by defining RX_SAMPLER_SYNC_EN.
module rx_bit_sampler #(
   parameter int PRESCALE_W = 6,
   parameter int DATA_BITS  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  par_en,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [3:0]            bit_count,
   output logic                  sample_bit,
   output logic                  sample_valid,
   output logic                  frame_done,
   output logic                  start_glitch
);

   logic [PRESCALE_W-1:0] edge_cnt_reg;
   logic [3:0]            bit_count_reg;
   logic                  sample_bit_reg;
   logic                  sample_valid_reg;
   logic                  frame_done_reg;
   logic                  start_glitch_reg;
   logic                  held_reg;
   logic                  samp_reg [0:2];

   logic                  rx_sync;
   logic                  run;
   logic                  majority;
   logic [PRESCALE_W-1:0] p_eff;
   logic [PRESCALE_W-1:0] p_last;
   logic [PRESCALE_W-1:0] p_half;
   logic [PRESCALE_W-1:0] vote_pt;
   logic [3:0]            last_bit;

`ifdef RX_SAMPLER_SYNC_EN
   logic sync_reg [0:1];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (reset) sync_reg[gi] <= 1'b1;
               else       sync_reg[gi] <= rx_in;
            end
         end else begin : g_rest
            always_ff @(posedge clk) begin
               if (reset) sync_reg[gi] <= 1'b1;
               else       sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign rx_sync = sync_reg[1];
`else
   assign rx_sync = rx_in;
`endif

   // Unsupported ratios fall back to 8x oversampling.
   assign p_eff    = (prescale == PRESCALE_W'(16) || prescale == PRESCALE_W'(32)) ?
                     prescale : PRESCALE_W'(8);
   assign p_last   = p_eff - PRESCALE_W'(1);
   assign p_half   = p_eff >> 1;
   assign vote_pt  = p_half + PRESCALE_W'(1);
   assign last_bit = par_en ? 4'(DATA_BITS + 2) : 4'(DATA_BITS + 1);
   assign run      = enable && !held_reg;
   assign majority = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & samp_reg[2]) |
                     (samp_reg[1] & samp_reg[2]);

   // Three consecutive samples centred on the bit midpoint.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_samp
         always_ff @(posedge clk) begin
            if (reset) begin
               samp_reg[gi] <= 1'b1;
            end else if (run &&
                         edge_cnt_reg == p_half - PRESCALE_W'(2) + PRESCALE_W'(gi)) begin
               samp_reg[gi] <= rx_sync;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         edge_cnt_reg     <= '0;
         bit_count_reg    <= '0;
         sample_bit_reg   <= 1'b1;
         sample_valid_reg <= 1'b0;
         frame_done_reg   <= 1'b0;
         start_glitch_reg <= 1'b0;
         held_reg         <= 1'b0;
      end else begin
         sample_valid_reg <= 1'b0;
         frame_done_reg   <= 1'b0;
         start_glitch_reg <= 1'b0;
         if (!enable) begin
            edge_cnt_reg  <= '0;
            bit_count_reg <= '0;
            held_reg      <= 1'b0;
         end else if (!held_reg) begin
            if (edge_cnt_reg == p_last) begin
               edge_cnt_reg  <= '0;
               bit_count_reg <= (bit_count_reg == last_bit) ? 4'd0 : bit_count_reg + 4'd1;
            end else begin
               edge_cnt_reg <= edge_cnt_reg + PRESCALE_W'(1);
            end
            if (edge_cnt_reg == vote_pt) begin
               sample_bit_reg   <= majority;
               sample_valid_reg <= 1'b1;
               // A high start bit is a false start: abort and park until enable re-arms.
               if (bit_count_reg == 4'd0 && majority) begin
                  start_glitch_reg <= 1'b1;
                  held_reg         <= 1'b1;
                  edge_cnt_reg     <= '0;
                  bit_count_reg    <= '0;
               end else if (bit_count_reg == last_bit) begin
                  frame_done_reg <= 1'b1;
               end
            end
         end
      end
   end

   assign edge_cnt     = edge_cnt_reg;
   assign bit_count    = bit_count_reg;
   assign sample_bit   = sample_bit_reg;
   assign sample_valid = sample_valid_reg;
   assign frame_done   = frame_done_reg;
   assign start_glitch = start_glitch_reg;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Directed bench for rx_bit_sampler: frames, glitches, aborts, reset and ratio fallback.
module tb_rx_bit_sampler;

   localparam int PW = 6;
   localparam int DB = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          rx_in;
   logic [PW-1:0] prescale;
   logic          par_en;
   logic [PW-1:0] edge_cnt;
   logic [3:0]    bit_count;
   logic          sample_bit;
   logic          sample_valid;
   logic          frame_done;
   logic          start_glitch;

   int total  = 0;
   int passed = 0;

   rx_bit_sampler #(.PRESCALE_W(PW), .DATA_BITS(DB)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .rx_in        (rx_in),
      .prescale     (prescale),
      .par_en       (par_en),
      .edge_cnt     (edge_cnt),
      .bit_count    (bit_count),
      .sample_bit   (sample_bit),
      .sample_valid (sample_valid),
      .frame_done   (frame_done),
      .start_glitch (start_glitch)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp)
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      else
         passed++;
   endtask

   // line[i] is the serial level during bit i; votes[i] the expected majority result.
   // Iteration n drives the inputs seen by the n-th enabled posedge and observes the
   // outputs produced by the previous one.
   task automatic run_frame(input string name, input logic [PW-1:0] psc, input int p,
                            input logic pe, input logic [11:0] line, input logic [11:0] votes,
                            input int nbits, input int inv_lo, input int inv_hi,
                            input int abort_at, input int reset_at, input int exp_pulses,
                            input int exp_done, input int exp_glitch);
      int   vcount = 0;
      int   dcount = 0;
      int   gcount = 0;
      int   last;
      int   first_stop;
      int   bi;
      bit   stopped = 1'b0;
      logic lvl;
      last       = DB + 1 + (pe ? 1 : 0);
      first_stop = nbits * p;
      if (abort_at >= 0 && abort_at + 1 < first_stop) first_stop = abort_at + 1;
      if (reset_at >= 0 && reset_at + 1 < first_stop) first_stop = reset_at + 1;
      @(negedge clk);
      prescale = psc;
      par_en   = pe;
      enable   = 1'b0;
      rx_in    = 1'b1;
      @(negedge clk);
      for (int n = 0; n < nbits * p + 4; n++) begin
         if (sample_valid) begin
            check({name, " strobe_time"}, n, vcount * p + p / 2 + 2);
            check({name, " bit_count@valid"}, bit_count, vcount);
            if (vcount < 12) check({name, " sample_bit"}, sample_bit, votes[vcount]);
            check({name, " frame_done@valid"}, frame_done, vcount == last);
            check({name, " start_glitch@valid"}, start_glitch, vcount == 0 && votes[0]);
            vcount++;
         end
         if (frame_done)   dcount++;
         if (start_glitch) gcount++;
         if (exp_glitch == 0 && n >= 1 && n < first_stop) begin
            check({name, " edge_cnt"}, edge_cnt, n % p);
            check({name, " bit_count"}, bit_count, n / p);
         end
         if (n == nbits * p) begin
            check({name, " end edge_cnt"}, edge_cnt, 0);
            check({name, " end bit_count"}, bit_count, 0);
         end
         if (reset_at >= 0 && n == reset_at + 1) begin
            check({name, " rst edge_cnt"}, edge_cnt, 0);
            check({name, " rst bit_count"}, bit_count, 0);
            check({name, " rst sample_bit"}, sample_bit, 1);
            check({name, " rst sample_valid"}, sample_valid, 0);
            check({name, " rst frame_done"}, frame_done, 0);
            check({name, " rst start_glitch"}, start_glitch, 0);
            reset   = 1'b0;
            stopped = 1'b1;
         end
         if (n == abort_at) stopped = 1'b1;
         if (reset_at >= 0 && n == reset_at) reset = 1'b1;
         enable = !stopped && (n < nbits * p);
         bi     = n / p;
         lvl    = (bi < 12) ? line[bi] : 1'b1;
         if (n >= inv_lo && n <= inv_hi) lvl = ~lvl;
         rx_in = lvl;
         @(negedge clk);
      end
      check({name, " pulse count"}, vcount, exp_pulses);
      check({name, " frame_done count"}, dcount, exp_done);
      check({name, " start_glitch count"}, gcount, exp_glitch);
      $display("frame %s: %0d strobes, %0d done, %0d glitch", name, vcount, dcount, gcount);
   endtask

   initial begin
      reset    = 1'b1;
      enable   = 1'b0;
      rx_in    = 1'b1;
      prescale = PW'(16);
      par_en   = 1'b0;
      repeat (2) @(negedge clk);
      check("reset edge_cnt", edge_cnt, 0);
      check("reset bit_count", bit_count, 0);
      check("reset sample_bit", sample_bit, 1);
      check("reset sample_valid", sample_valid, 0);
      check("reset frame_done", frame_done, 0);
      check("reset start_glitch", start_glitch, 0);
      reset = 1'b0;

      run_frame("p16_a5", PW'(16), 16, 1'b0, {3'b111, 8'hA5, 1'b0}, {3'b111, 8'hA5, 1'b0},
                10, -1, -1, -1, -1, 10, 1, 0);
      run_frame("p8_par_3c", PW'(8), 8, 1'b1, {2'b11, 1'b0, 8'h3C, 1'b0},
                {2'b11, 1'b0, 8'h3C, 1'b0}, 11, -1, -1, -1, -1, 11, 1, 0);
      run_frame("p16_spike", PW'(16), 16, 1'b0, {3'b111, 8'hA5, 1'b0}, {3'b111, 8'hA5, 1'b0},
                10, 39, 39, -1, -1, 10, 1, 0);
      run_frame("p16_false_start", PW'(16), 16, 1'b0, 12'hFFE, 12'hFFF,
                10, 6, 15, -1, -1, 1, 0, 1);
      run_frame("p16_reset_b4", PW'(16), 16, 1'b0, {3'b111, 8'h5A, 1'b0}, {3'b111, 8'h5A, 1'b0},
                10, -1, -1, -1, 67, 4, 0, 0);
      run_frame("p16_abort_b5", PW'(16), 16, 1'b0, {3'b111, 8'hA5, 1'b0}, {3'b111, 8'hA5, 1'b0},
                10, -1, -1, 82, -1, 5, 0, 0);
      run_frame("p12_as_p8", PW'(12), 8, 1'b0, {3'b111, 8'hA5, 1'b0}, {3'b111, 8'hA5, 1'b0},
                10, -1, -1, -1, -1, 10, 1, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rx_bit_sampler.md
# rx_bit_sampler

Oversampling front end of the UART receive path, directly upstream of the deserializer. It tracks the oversampling edge position and frame bit index for the incoming serial line. At each bit centre it takes a 3-sample majority vote and issues a one-cycle strobe with the resolved bit. The deserializer, parity check and stop check consume `sample_bit`, `bit_count` and `sample_valid`; the RX FSM drives `enable` and reacts to `frame_done` and `start_glitch`.

## Interface
- `PRESCALE_W`, 6: width of `prescale` and `edge_cnt`.
- `DATA_BITS`, 8: data bits per frame.
- `clk` in 1: receive clock (oversampling clock).
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: from RX FSM; high for the whole frame, starting the cycle after the start-bit falling edge is detected.
- `rx_in` in 1: serial line, idle high.
- `prescale` in PRESCALE_W: oversampling ratio; legal values 8, 16, 32; must stay stable while `enable` is high.
- `par_en` in 1: frame carries a parity bit; must stay stable while `enable` is high.
- `edge_cnt` out PRESCALE_W: edge position within the current bit, 0..P-1.
- `bit_count` out 4: bit index; 0 = start, 1..DATA_BITS = data, then parity (if `par_en`), then stop.
- `sample_bit` out 1: majority-voted value of the most recent bit.
- `sample_valid` out 1: one-cycle strobe; `sample_bit` is fresh.
- `frame_done` out 1: one-cycle strobe coincident with `sample_valid` of the stop bit.
- `start_glitch` out 1: one-cycle strobe; start bit voted high and frame aborted.

## Operation
- Effective ratio P = `prescale` if it is 8, 16 or 32; any other value is treated as P = 8.
- Last bit index L = DATA_BITS+1 without parity, DATA_BITS+2 with `par_en`.
- Edge counting while `enable` is high:
  - `edge_cnt` increments every cycle.
  - At `edge_cnt == P-1`, `edge_cnt` wraps to 0 and `bit_count` increments.
- Sample capture: `rx_in` (after the optional synchroniser) is captured into s0, s1, s2 at `edge_cnt` = P/2-2, P/2-1 and P/2.
- Vote: the cycle after s2 is captured, `sample_bit` <= majority(s0, s1, s2) and `sample_valid` pulses.
- `bit_count` is stable across the vote, so a downstream register using `bit_count` with `sample_valid` sees the correct index.
- Start check: if `bit_count == 0` and the voted bit is 1:
  - `start_glitch` pulses together with `sample_valid`.
  - `edge_cnt` and `bit_count` clear to 0 on the next cycle and stay held until `enable` goes low and then high again.
- Frame end: at `bit_count == L`, `frame_done` pulses together with that bit's `sample_valid`.
  - When the edge counter next wraps, both counters clear to 0 instead of `bit_count` going to L+1.
- `enable` low: on the next edge both counters clear to 0 and no strobes are issued; `sample_bit` holds its value.
- Dropping `enable` mid-frame aborts silently. `frame_done` is not issued.
- `enable` rising resumes counting from `edge_cnt` 0, `bit_count` 0.

## Timing
- Reset values: `edge_cnt` 0, `bit_count` 0, `sample_bit` 1, `sample_valid` 0, `frame_done` 0, `start_glitch` 0; s0..s2 = 1; synchroniser flops = 1.
- Reset is synchronous; asserting it mid-frame drops the frame with no strobes. Reset overrides `enable`.
- Latency, with the first `enable`-high cycle at `edge_cnt` 0:
  - The `sample_valid` for bit k lands k·P + P/2 + 1 cycles after `enable` rises.
  - With P = 16, the start-bit vote appears 9 cycles after `enable` rises.
- Exactly one `sample_valid` per bit; at most one of `frame_done` or `start_glitch` per frame.

## Configuration
- `RX_SAMPLER_SYNC_EN` defined:
  - `rx_in` passes through a two-flop synchroniser, reset value 1, before capture.
  - Sample points are unchanged relative to `edge_cnt`; the line is effectively sampled 2 cycles later. The RX FSM's start detect must account for this.
- Not defined: `rx_in` is captured directly and assumed already synchronous to `clk`.

## Test plan
- P=16, `par_en`=0, frame 0xA5 LSB-first with valid start/stop:
  - 10 `sample_valid` pulses, at `bit_count` 0..9.
  - Data votes 1,0,1,0,0,1,0,1.
  - `frame_done` at `bit_count` 9; counters back to 0 afterwards.
- P=8, `par_en`=1, frame 0x3C with parity 0:
  - 11 pulses; `frame_done` at `bit_count` 10.
  - Start-bit strobe 5 cycles after `enable` rises.
- P=16, one-cycle high glitch on `rx_in` at `edge_cnt` 7 of a data bit that is otherwise 0: voted 0 (majority holds).
- P=16, `rx_in` returns high before the start-bit centre: `start_glitch` at `bit_count` 0, no `frame_done`, counters held at 0.
- Robustness:
  - `reset` asserted at `bit_count` 4: all outputs at reset values next cycle.
  - `enable` dropped at `bit_count` 5: no further strobes.
  - `prescale` = 12: behaves identically to P = 8.
